// File: rtl/sdp_ram_be_if.sv
// Write/read/status bundle for sdp_ram_be.
// SDP_RAM_PARITY_EN adds err_inj (master to slave) and parity_err (slave to master).
interface sdp_ram_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  wren;
    logic [NB-1:0]         wrbe;
    logic [ADDR_WIDTH-1:0] addrwr;
    logic [DATA_WIDTH-1:0] din;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] addrrd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  busy;
`ifdef SDP_RAM_PARITY_EN
    logic                  err_inj;
    logic [NB-1:0]         parity_err;

    modport master (
        output wren, wrbe, addrwr, din, rden, addrrd, err_inj,
        input  dout, dout_vld, busy, parity_err
    );
    modport slave (
        input  wren, wrbe, addrwr, din, rden, addrrd, err_inj,
        output dout, dout_vld, busy, parity_err
    );
`else
    modport master (
        output wren, wrbe, addrwr, din, rden, addrrd,
        input  dout, dout_vld, busy
    );
    modport slave (
        input  wren, wrbe, addrwr, din, rden, addrrd,
        output dout, dout_vld, busy
    );
`endif
endinterface

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: byte-lane writes, 1- or 2-cycle reads, array cleared after reset.
// Define SDP_RAM_PARITY_EN for per-lane even parity with error injection.
module sdp_ram_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned RDW_MODE   = 1
) (
    input logic         clk,
    input logic         rst_n,
    sdp_ram_be_if.slave bus
);
    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sdp_ram_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef logic [NB-1:0][BYTE_WIDTH-1:0] word_t;
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clearing, wr_fire, rd_fire, collide;
    word_t                 mem [DEPTH];
    word_t                 din_w, rd_merged;
    word_t                 s_data, dout_q;
    logic                  s_vld, dout_vld_q;

    assign clearing = (state_q == StClear);
    assign wr_fire  = bus.wren & ~clearing;
    assign rd_fire  = bus.rden & ~clearing;
    assign collide  = wr_fire & rd_fire & (bus.addrwr == bus.addrrd);
    assign din_w    = bus.din;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = StRun;
            end
            StRun: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

`ifdef SDP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par, rd_par, rd_err, s_err, perr_q;

    // err_inj flips the stored bit so a later read of that lane reports a mismatch
    always_comb begin
        for (int i = 0; i < int'(NB); i++) wr_par[i] = (^din_w[i]) ^ bus.err_inj;
    end
`endif

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_addr_q] <= '0;
`ifdef SDP_RAM_PARITY_EN
            par_mem[clr_addr_q] <= '0;
`endif
        end else if (wr_fire) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.wrbe[i]) begin
                    mem[bus.addrwr][i] <= din_w[i];
`ifdef SDP_RAM_PARITY_EN
                    par_mem[bus.addrwr][i] <= wr_par[i];
`endif
                end
            end
        end
    end

    // Write-first collisions forward the enabled lanes of din; the array write proceeds anyway.
    always_comb begin
        rd_merged = mem[bus.addrrd];
        if (RDW_MODE == 1 && collide) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.wrbe[i]) rd_merged[i] = din_w[i];
            end
        end
    end

`ifdef SDP_RAM_PARITY_EN
    always_comb begin
        rd_par = par_mem[bus.addrrd];
        if (RDW_MODE == 1 && collide) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.wrbe[i]) rd_par[i] = wr_par[i];
            end
        end
        for (int i = 0; i < int'(NB); i++) rd_err[i] = (^rd_merged[i]) ^ rd_par[i];
    end
`endif

    if (RD_LATENCY == 1) begin : g_lat1
        assign s_vld  = rd_fire;
        assign s_data = rd_merged;
`ifdef SDP_RAM_PARITY_EN
        assign s_err  = rd_err;
`endif
    end else begin : g_lat2
        logic  s1_vld_q;
        word_t s1_data_q;
`ifdef SDP_RAM_PARITY_EN
        logic [NB-1:0] s1_err_q;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
`ifdef SDP_RAM_PARITY_EN
                s1_err_q  <= '0;
`endif
            end else begin
                s1_vld_q <= rd_fire;
                if (rd_fire) begin
                    s1_data_q <= rd_merged;
`ifdef SDP_RAM_PARITY_EN
                    s1_err_q  <= rd_err;
`endif
                end
            end
        end
        assign s_vld  = s1_vld_q;
        assign s_data = s1_data_q;
`ifdef SDP_RAM_PARITY_EN
        assign s_err  = s1_err_q;
`endif
    end

    // dout keeps its last value between results; only dout_vld drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
            perr_q     <= '0;
`endif
        end else begin
            dout_vld_q <= s_vld;
            if (s_vld) dout_q <= s_data;
`ifdef SDP_RAM_PARITY_EN
            perr_q <= s_vld ? s_err : '0;
`endif
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.busy     = clearing;
`ifdef SDP_RAM_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule
